// File: rtl/spell_mem_initiator.sv
// Single-outstanding memory initiator bridging a core request port to a spell-memory responder.
// Optional abort-on-timeout is enabled by defining SPELL_MEM_TIMEOUT_EN.
module spell_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_data_type,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_memory_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready
);

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t          state, state_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_data_in_nxt;
  logic            mem_type_nxt;
  logic            mem_write_nxt;
  logic [DW-1:0]   rsp_rdata_nxt;

`ifdef SPELL_MEM_TIMEOUT_EN
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            rsp_error_q, rsp_error_nxt;
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  // Next-state and next-value decode
  always_comb begin
    state_nxt       = state;
    mem_addr_nxt    = mem_addr;
    mem_data_in_nxt = mem_data_in;
    mem_type_nxt    = mem_memory_type_data;
    mem_write_nxt   = mem_write;
    rsp_rdata_nxt   = rsp_rdata;
`ifdef SPELL_MEM_TIMEOUT_EN
    cnt_nxt         = cnt;
    rsp_error_nxt   = rsp_error_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_addr_nxt    = req_addr;
          mem_data_in_nxt = req_wdata;
          mem_type_nxt    = req_data_type;
          mem_write_nxt   = req_write;
`ifdef SPELL_MEM_TIMEOUT_EN
          cnt_nxt         = CW'(0);
`endif
          state_nxt       = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_data_ready) begin
          if (!mem_write) rsp_rdata_nxt = mem_data_out;
`ifdef SPELL_MEM_TIMEOUT_EN
          rsp_error_nxt = 1'b0;
`endif
          state_nxt = RESP;
        end
`ifdef SPELL_MEM_TIMEOUT_EN
        else begin
          // Saturating count; completion above takes priority over abort
          if (cnt != {CW{1'b1}}) cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(TIMEOUT_CYCLES)) begin
            rsp_error_nxt = 1'b1;
            state_nxt     = RESP;
          end
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; select/valid track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      mem_select           <= 1'b0;
      mem_addr             <= '0;
      mem_data_in          <= '0;
      mem_memory_type_data <= 1'b0;
      mem_write            <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
`ifdef SPELL_MEM_TIMEOUT_EN
      cnt                  <= '0;
      rsp_error_q          <= 1'b0;
`endif
    end else begin
      state                <= state_nxt;
      mem_select           <= (state_nxt == ACCESS);
      mem_addr             <= mem_addr_nxt;
      mem_data_in          <= mem_data_in_nxt;
      mem_memory_type_data <= mem_type_nxt;
      mem_write            <= mem_write_nxt;
      rsp_valid            <= (state_nxt == RESP);
      rsp_rdata            <= rsp_rdata_nxt;
`ifdef SPELL_MEM_TIMEOUT_EN
      cnt                  <= cnt_nxt;
      rsp_error_q          <= rsp_error_nxt;
`endif
    end
  end

endmodule

// File: doc/spell_mem_initiator.md
SPELL_MEM_INITIATOR -- requirements
Module: spell_mem_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd255, sets the maximum number of ACCESS cycles before abort; legal range 1..255.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  core requests a memory transaction.
REQ-005 req_ready  output  1  initiator can accept a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_data_type  input  1  1 = data space, 0 = code space.
REQ-008 req_addr  input  8  transaction address.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle response strobe.
REQ-011 rsp_rdata  output  8  read data; valid while rsp_valid is high.
REQ-012 rsp_error  output  1  transaction aborted by timeout; valid while rsp_valid is high.
REQ-013 mem_select  output  1  drives the responder select.
REQ-014 mem_addr  output  8  drives the responder addr.
REQ-015 mem_data_in  output  8  drives the responder data_in.
REQ-016 mem_memory_type_data  output  1  drives the responder memory_type_data.
REQ-017 mem_write  output  1  drives the responder write.
REQ-018 mem_data_out  input  8  responder read data.
REQ-019 mem_data_ready  input  1  responder completion flag.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE, decoded combinationally from state.
REQ-022 In IDLE with req_valid=1, the block SHALL register req_addr, req_wdata, req_write and req_data_type into the mem_* outputs, clear the timeout counter and enter ACCESS.
REQ-023 mem_select SHALL be 1 only in ACCESS; mem_addr, mem_data_in, mem_write and mem_memory_type_data SHALL remain stable for the whole ACCESS interval.
REQ-024 In ACCESS, when mem_data_ready=1 at a clock edge, the block SHALL capture mem_data_out into rsp_rdata (reads only; on writes rsp_rdata holds its previous value), clear rsp_error and enter RESP.
REQ-025 The timeout counter SHALL increment by 1 on every ACCESS cycle in which mem_data_ready=0; it is 8 bits wide and SHALL never wrap.
REQ-026 In RESP, rsp_valid SHALL be 1 for exactly one cycle and mem_select SHALL be 0; the next state SHALL be IDLE unconditionally.
REQ-027 There SHALL be no back-to-back requests: mem_select is low for at least two cycles (RESP, IDLE) between transactions.
REQ-028 Minimum latency: request accepted at edge N, mem_select high in cycle N+1, rsp_valid high in cycle N+2 when the responder is ready in the first ACCESS cycle.
REQ-029 If mem_data_ready and the timeout condition occur in the same cycle, completion SHALL win (rsp_error=0).
REQ-030 mem_data_ready SHALL be ignored outside ACCESS.

Reset
REQ-031 While rst_n=0: state=IDLE; mem_select, mem_write and mem_memory_type_data = 0; mem_addr and mem_data_in = 8'h00; rsp_valid and rsp_error = 0; rsp_rdata = 8'h00; counter = 0.
REQ-032 Reset asserted during ACCESS SHALL drop mem_select immediately (asynchronously) and discard the transaction with no response.

Configuration
REQ-033 Macro SPELL_MEM_TIMEOUT_EN: when defined, the block SHALL leave ACCESS for RESP with rsp_error=1 and rsp_rdata unchanged once the counter equals TIMEOUT_CYCLES and mem_data_ready=0.
REQ-034 When SPELL_MEM_TIMEOUT_EN is undefined, the counter SHALL be omitted, ACCESS SHALL wait indefinitely for mem_data_ready, and rsp_error SHALL be constant 0.

Verification
REQ-035 Read, responder ready in the first cycle: req addr=8'h10, data_type=1, mem_data_out=8'hA5 -> mem_select high for 1 cycle, rsp_valid at N+2, rsp_rdata=8'hA5, rsp_error=0.
REQ-036 Write with ready delayed 5 cycles: addr=8'h30, wdata=8'h5A -> mem_* stable and mem_select high for 6 cycles, then one rsp_valid; rsp_rdata unchanged.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=4, responder never ready) -> rsp_valid with rsp_error=1 after 4 counted ACCESS cycles, then IDLE and req_ready=1.
REQ-038 Ready coincident with timeout (macro defined) -> rsp_error=0 and rsp_rdata captured.
REQ-039 rst_n pulsed low in the 2nd ACCESS cycle -> mem_select falls within the same cycle, no rsp_valid, all outputs at their reset values.
REQ-040 req_valid held high continuously -> accepts occur only in IDLE, with at least a two-cycle gap between mem_select pulses.
